// File: rtl/arith_sequencer.sv
// rtl/arith_sequencer.sv - control FSM sequencing the shared mul/div/sqrt shift datapath
// Issues clear/load/shift/update strobes for N iterations and reports done/error.
module arith_sequencer #(
    parameter int WORD_LENGTH = 8,
    parameter int CNT_W       = $clog2(WORD_LENGTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             abort,
    input  logic             divisor_zero,
    output logic             dp_clear,
    output logic             dp_load,
    output logic             dp_shift,
    output logic             dp_update,
    output logic [1:0]       op_latched,
    output logic [CNT_W-1:0] iter_count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD   = 3'd2,
        S_SHIFT  = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] OP_DIV     = 2'b01;
    localparam logic [1:0] OP_SQRT    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [CNT_W-1:0] N_FULL = CNT_W'(WORD_LENGTH);
    localparam logic [CNT_W-1:0] N_HALF = CNT_W'(WORD_LENGTH / 2);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] n_iter;

    assign n_iter = (op_q == OP_SQRT) ? N_HALF : N_FULL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    // Abort overrides the normal Moore decode: it clears the datapath and drops to IDLE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        iter_d    = iter_q;
        err_d     = err_q;
        dp_clear  = 1'b0;
        dp_load   = 1'b0;
        dp_shift  = 1'b0;
        dp_update = 1'b0;
        done      = 1'b0;
        if (state_q != S_IDLE && abort) begin
            state_d  = S_IDLE;
            dp_clear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d = op;
                        if (op == OP_ILLEGAL) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            err_d   = 1'b0;
                            state_d = S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    dp_clear = 1'b1;
                    iter_d   = '0;
                    state_d  = S_LOAD;
                end
                S_LOAD: begin
                    dp_load = 1'b1;
                    if (op_q == OP_DIV && divisor_zero) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    dp_shift = 1'b1;
                    state_d  = S_UPDATE;
                end
                S_UPDATE: begin
                    dp_update = 1'b1;
                    iter_d    = iter_q + CNT_W'(1);
                    state_d   = (iter_d == n_iter) ? S_DONE : S_SHIFT;
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign op_latched = op_q;
    assign iter_count = iter_q;
    assign error      = err_q;

endmodule

// File: tb/tb_arith_sequencer.sv
// tb/tb_arith_sequencer.sv - directed self-checking bench for arith_sequencer
module tb_arith_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic       abort;
    logic       divisor_zero;
    logic       dp_clear, dp_load, dp_shift, dp_update;
    logic [1:0] op_latched;
    logic [3:0] iter_count;
    logic       busy, done, error;

    int n_total = 0;
    int n_bad   = 0;

    arith_sequencer #(.WORD_LENGTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .abort        (abort),
        .divisor_zero (divisor_zero),
        .dp_clear     (dp_clear),
        .dp_load      (dp_load),
        .dp_shift     (dp_shift),
        .dp_update    (dp_update),
        .op_latched   (op_latched),
        .iter_count   (iter_count),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Cycle 1 is the cycle right after the start edge E0.
    task automatic run_op(input logic [1:0] opc, input logic dz,
                          output int done_cyc, output int n_clr, output int n_load,
                          output int n_shift, output int n_upd, output int n_done,
                          output int n_multi, output logic err_c1,
                          output logic busy_after, output logic done_after);
        int s;
        @(negedge clk);
        start = 1'b1; op = opc; divisor_zero = dz;
        @(posedge clk); #1;
        start = 1'b0;
        err_c1 = error;
        done_cyc = -1; n_clr = 0; n_load = 0; n_shift = 0; n_upd = 0; n_done = 0; n_multi = 0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            s = int'(dp_clear) + int'(dp_load) + int'(dp_shift) + int'(dp_update) + int'(done);
            if (s > 1) n_multi++;
            n_clr   += int'(dp_clear);
            n_load  += int'(dp_load);
            n_shift += int'(dp_shift);
            n_upd   += int'(dp_update);
            n_done  += int'(done);
            if (done) done_cyc = c;
        end
        @(posedge clk); #1;
        busy_after = busy;
        done_after = done;
    endtask

    int   dc, nc, nl, ns, nu, nd, nm;
    logic e1, ba, da;
    int   d1, d2, idle_between;
    logic saw_done;

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; abort = 1'b0; divisor_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_iter", iter_count, 0);
        check("rst_op", op_latched, 0);
        check("rst_strobes", {dp_clear, dp_load, dp_shift, dp_update}, 0);
        @(negedge clk); reset = 1'b0;

        run_op(2'b00, 1'b0, dc, nc, nl, ns, nu, nd, nm, e1, ba, da);
        check("mul_done_cyc", dc, 19);
        check("mul_clear", nc, 1);
        check("mul_load", nl, 1);
        check("mul_shift", ns, 8);
        check("mul_update", nu, 8);
        check("mul_onehot", nm, 0);
        check("mul_iter", iter_count, 8);
        check("mul_error", error, 0);
        check("mul_busy_after", ba, 0);
        check("mul_done_after", da, 0);

        run_op(2'b10, 1'b0, dc, nc, nl, ns, nu, nd, nm, e1, ba, da);
        check("sqrt_done_cyc", dc, 11);
        check("sqrt_shift", ns, 4);
        check("sqrt_iter", iter_count, 4);
        check("sqrt_op", op_latched, 2);

        run_op(2'b01, 1'b0, dc, nc, nl, ns, nu, nd, nm, e1, ba, da);
        check("div_done_cyc", dc, 19);
        check("div_error", error, 0);

        run_op(2'b01, 1'b1, dc, nc, nl, ns, nu, nd, nm, e1, ba, da);
        check("div0_done_cyc", dc, 3);
        check("div0_shift", ns, 0);
        check("div0_error", error, 1);

        run_op(2'b00, 1'b0, dc, nc, nl, ns, nu, nd, nm, e1, ba, da);
        check("clr_err_at_accept", e1, 0);
        check("mul2_done_cyc", dc, 19);

        run_op(2'b11, 1'b0, dc, nc, nl, ns, nu, nd, nm, e1, ba, da);
        check("ill_done_cyc", dc, 1);
        check("ill_error", error, 1);
        check("ill_strobes", nc + nl + ns + nu, 0);
        check("ill_op", op_latched, 3);

        // Abort during the 5th UPDATE of a MUL, with a stray start/op mid-run.
        @(negedge clk); start = 1'b1; op = 2'b00;
        @(posedge clk); #1; start = 1'b0;
        saw_done = 1'b0;
        for (int c = 2; c <= 12; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            if (c == 5) begin start = 1'b1; op = 2'b10; end
            if (c == 6) start = 1'b0;
        end
        check("ab_op_kept", op_latched, 0);
        check("ab_in_update", dp_update, 1);
        abort = 1'b1;
        #1;
        check("ab_clear", dp_clear, 1);
        check("ab_update_low", dp_update, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_idle", busy, 0);
        check("ab_iter", iter_count, 4);
        check("ab_error_kept", error, 0);
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("ab_no_done", saw_done, 0);

        // Asynchronous reset during SHIFT.
        @(negedge clk); start = 1'b1; op = 2'b10;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rs_in_shift", dp_shift, 1);
        #2; reset = 1'b1; #1;
        check("rs_busy", busy, 0);
        check("rs_op", op_latched, 0);
        check("rs_iter", iter_count, 0);
        check("rs_strobes", {dp_clear, dp_load, dp_shift, dp_update, done}, 0);

        // Back-to-back SQRT with start held high from reset release.
        @(negedge clk); start = 1'b1; op = 2'b10; reset = 1'b0;
        d1 = -1; d2 = -1; idle_between = 0;
        for (int c = 1; c <= 40 && d2 < 0; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end else if (d1 >= 0 && !busy) begin
                idle_between++;
            end
        end
        start = 1'b0;
        check("b2b_first", d1, 11);
        check("b2b_gap", d2 - d1, 12);
        check("b2b_idle", idle_between, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
